// File: rtl/bits_capture_pkg.sv
// bits_capture_pkg: shared read-address map, read-FSM state and read-data width for bits_capture.
package bits_capture_pkg;
  localparam int RD_DW = 32;
  localparam logic [1:0] ADDR_VALUE   = 2'd0;
  localparam logic [1:0] ADDR_CHANGES = 2'd1;
  localparam logic [1:0] ADDR_SEQ     = 2'd2;
  typedef enum logic {IDLE, ACK} rd_state_e;
endpackage

// File: rtl/bits_edge_detect.sv
// bits_edge_detect: registers the bit bus and accumulates a sticky per-bit change mask.
module bits_edge_detect #(
  parameter int NBITS = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic [NBITS-1:0] bits_i,
  output logic [NBITS-1:0] edges_o,
  output logic [NBITS-1:0] bits_q_o,
  output logic [NBITS-1:0] chg_live_o
);
  logic             r_first;
  logic [NBITS-1:0] r_bits_q;
  logic [NBITS-1:0] r_chg_live;
  // bits_q is not yet meaningful in the first cycle after reset, so no edge is reported then
  assign edges_o    = r_first ? '0 : (bits_i ^ r_bits_q);
  assign bits_q_o   = r_bits_q;
  assign chg_live_o = r_chg_live;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_first    <= 1'b1;
      r_bits_q   <= '0;
      r_chg_live <= '0;
    end else begin
      r_first    <= 1'b0;
      r_bits_q   <= bits_i;
      r_chg_live <= clr_i ? '0 : (r_chg_live | edges_o);
    end
  end
endmodule

// File: rtl/bits_capture.sv
// bits_capture: snapshots the bit bus and its sticky change mask for register reads.
// Optional change interrupt is enabled by defining BITS_CAPTURE_IRQ_EN.
module bits_capture
  import bits_capture_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int SEQW  = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [NBITS-1:0] bits_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_addr_i,
  output logic             rd_ack_o,
  output logic [RD_DW-1:0] rd_data_o,
  output logic             irq_o
);
  rd_state_e        r_state, w_next;
  logic [1:0]       r_addr;
  logic [NBITS-1:0] r_snap_val, r_snap_chg;
  logic [SEQW-1:0]  r_seq;
  logic [NBITS-1:0] w_edges, w_bits_q, w_chg_live;
  logic             w_start, w_value_rd, w_ack;
  assign w_start    = (r_state == IDLE) && rd_req_i;
  assign w_value_rd = w_start && (rd_addr_i == ADDR_VALUE);
  bits_edge_detect #(.NBITS(NBITS)) u_edge (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (w_value_rd),
    .bits_i     (bits_i),
    .edges_o    (w_edges),
    .bits_q_o   (w_bits_q),
    .chg_live_o (w_chg_live)
  );
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_snap_val <= '0;
      r_snap_chg <= '0;
      r_seq      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_addr <= rd_addr_i;
      if (w_value_rd) begin
        r_snap_val <= w_bits_q;
        r_snap_chg <= w_chg_live | w_edges;
        r_seq      <= r_seq + SEQW'(1);
      end
    end
  end
  always_comb w_next = w_start ? ACK : IDLE;
  // a reset landing in the ACK cycle kills that acknowledge immediately
  assign w_ack = (r_state == ACK) && !reset_i;
  always_comb begin
    rd_ack_o  = w_ack;
    rd_data_o = !w_ack                    ? '0 :
                (r_addr == ADDR_VALUE)    ? RD_DW'(r_snap_val) :
                (r_addr == ADDR_CHANGES)  ? RD_DW'(r_snap_chg) :
                (r_addr == ADDR_SEQ)      ? RD_DW'(r_seq) : '0;
  end
`ifdef BITS_CAPTURE_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk_i) r_irq <= reset_i ? 1'b0 : |w_chg_live;
  assign irq_o = r_irq;
`else
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_bits_capture.sv
// tb_bits_capture: scoreboard bench for bits_capture (NBITS=8, SEQW=4); honours BITS_CAPTURE_IRQ_EN.
module tb_bits_capture;
  localparam int NBITS = 8;
  localparam int SEQW  = 4;
`ifdef BITS_CAPTURE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NBITS-1:0] bits = '0;
  logic             rd_req = 1'b0;
  logic [1:0]       rd_addr = '0;
  logic             rd_ack;
  logic [31:0]      rd_data;
  logic             irq;
  logic [31:0]      exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               exp_seq = 0;

  bits_capture #(.NBITS(NBITS), .SEQW(SEQW)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .bits_i    (bits),
    .rd_req_i  (rd_req),
    .rd_addr_i (rd_addr),
    .rd_ack_o  (rd_ack),
    .rd_data_o (rd_data),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    exp_seq = 0;
  endtask

  task automatic do_read(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    int          waited;
    if (a == 2'd0) exp_seq = (exp_seq + 1) % (1 << SEQW);
    exp_q.push_back(a == 2'd2 ? 32'(exp_seq) : exp);
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = a;
    @(negedge clk) rd_req = 1'b0;
    waited = 0;
    while (!rd_ack && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (waited != 0 || !rd_ack) begin
      n_err++;
      $display("FAIL %s latency: ack after %0d extra cycles, ack=%0b, required 0 extra", name, waited, rd_ack);
    end else if (rd_data !== e) begin
      n_err++;
      $display("FAIL %s data: got 0x%08h required 0x%08h", name, rd_data, e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (rd_ack !== 1'b0 || rd_data !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: ack=%0b data=0x%08h irq=%0b required 0/0/0", rd_ack, rd_data, irq);
    end
    reset = 1'b0;
    exp_seq = 0;
    bits = '0;
    repeat (2) @(negedge clk);
    do_read("t1_value", 2'd0, 32'h0);
    do_read("t1_changes", 2'd1, 32'h0);
    do_read("t1_seq", 2'd2, 32'h0);
  endtask

  task automatic test_pulse();
    @(negedge clk) bits = 8'h05;
    @(negedge clk) bits = 8'h00;
    @(negedge clk);
    do_read("t2_value", 2'd0, 32'h0);
    do_read("t2_changes", 2'd1, 32'h5);
    do_read("t3_value", 2'd0, 32'h0);
    do_read("t3_changes", 2'd1, 32'h0);
  endtask

  task automatic test_edge_in_read_cycle();
    exp_seq = (exp_seq + 1) % (1 << SEQW);
    exp_q.push_back(32'h0);
    @(negedge clk);
    bits = 8'h08;
    rd_req = 1'b1;
    rd_addr = 2'd0;
    @(negedge clk) rd_req = 1'b0;
    n_cmp++;
    if (rd_ack !== 1'b1 || rd_data !== exp_q[0]) begin
      n_err++;
      $display("FAIL t4_value: ack=%0b data=0x%08h required 1/0x%08h", rd_ack, rd_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    do_read("t4_changes", 2'd1, 32'h8);
    do_read("t5_value", 2'd0, 32'h8);
    do_read("t5_changes", 2'd1, 32'h0);
  endtask

  task automatic test_double_toggle();
    @(negedge clk) bits = 8'h48;
    @(negedge clk) bits = 8'h08;
    @(negedge clk) bits = 8'h48;
    @(negedge clk);
    do_read("toggle2_value", 2'd0, 32'h48);
    do_read("toggle2_changes", 2'd1, 32'h40);
  endtask

  task automatic test_seq_wrap();
    int guard = 0;
    bits = 8'hA5;
    @(negedge clk);
    do_read("wrap_value0", 2'd0, 32'hA5);
    while (exp_seq != 0 && guard < 40) begin
      do_read("wrap_value", 2'd0, 32'hA5);
      guard++;
    end
    do_read("t6_seq_wrapped", 2'd2, 32'h0);
    n_cmp++;
    if (exp_seq != 0) begin
      n_err++;
      $display("FAIL t6_wrap_model: model seq %0d required 0", exp_seq);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    logic [31:0] e;
    exp_q.push_back(32'(exp_seq));
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = 2'd2;
    @(negedge clk);
    if (rd_ack) begin
      acks++;
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== e) begin
        n_err++;
        $display("FAIL t7_data: got 0x%08h required 0x%08h", rd_data, e);
      end
    end
    rd_req = 1'b1;
    @(negedge clk) rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rd_ack) acks++;
      @(negedge clk);
    end
    n_cmp++;
    if (acks != 1) begin
      n_err++;
      $display("FAIL t7_single_ack: got %0d acks required 1", acks);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_in_ack();
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = 2'd2;
    @(negedge clk);
    rd_req = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rd_ack !== 1'b0 || rd_data !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL t8_ack_suppressed: ack=%0b data=0x%08h irq=%0b required 0/0/0", rd_ack, rd_data, irq);
    end
    @(negedge clk) reset = 1'b0;
    exp_seq = 0;
    n_cmp++;
    if (rd_ack !== 1'b0 || rd_data !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL t8_after_reset: ack=%0b data=0x%08h irq=%0b required 0/0/0", rd_ack, rd_data, irq);
    end
    do_read("t8_seq", 2'd2, 32'h0);
    do_read("t8_changes", 2'd1, 32'h0);
  endtask

  task automatic test_irq();
    do_reset();
    bits = '0;
    repeat (2) @(negedge clk);
    bits = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_1cycle: got %0b required 0", irq);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      n_err++;
      $display("FAIL t9_irq_2cycles: got %0b required %0b", irq, IRQ_ON);
    end
    do_read("t10_value", 2'd0, 32'h1);
    n_cmp++;
    if (irq !== IRQ_ON) begin
      n_err++;
      $display("FAIL irq_in_ack: got %0b required %0b", irq, IRQ_ON);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL t10_irq_cleared: got %0b required 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_pulse();
    test_edge_in_read_cycle();
    test_double_toggle();
    test_seq_wrap();
    test_back_to_back();
    test_reset_in_ack();
    test_irq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
